// File: rtl/online_digit_sequencer.sv
// online_digit_sequencer: buffers signed-digit operand pairs, feeds the online multiplier, owns cnt_master.
// Optional macro ONLINE_DIGIT_CHECK_EN: squash illegal 10 digits to 00 on push and raise sticky digit_err.
module online_digit_sequencer #(
    parameter int NDIGITS      = 32,
    parameter int ONLINE_DELAY = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [1:0] in_x,
    input  logic [1:0] in_y,
    output logic       in_ready,
    input  logic       enable_for_input,
    output logic [1:0] x_digit,
    output logic [1:0] y_digit,
    output logic       digit_valid,
    output logic [8:0] cnt_master,
    output logic       write_enable,
    output logic       busy,
    output logic       done,
    output logic       digit_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [8:0] LAST = 9'(4 * (NDIGITS + ONLINE_DELAY) - 1);

    typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [9:0]  issued_q, issued_d;
    logic        done_q, done_d, we_q, we_d, err_q, err_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [3:0]  mem_q [FIFO_DEPTH];
    logic [3:0]  mem_d [FIFO_DEPTH];
    logic        empty, full, push, pop, operand, stall;
    logic [1:0]  px, py;

    always_comb begin
        empty       = wr_q == rd_q;
        full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push        = in_valid && !full;
        operand     = issued_q < 10'(NDIGITS);
        digit_valid = (state_q == RUN) && (!operand || !empty);
        stall       = (state_q == RUN) && enable_for_input && operand && empty;
        pop         = (state_q == RUN) && enable_for_input && operand && !empty;
        x_digit     = operand ? mem_q[rd_q[AW-1:0]][3:2] : 2'b00;
        y_digit     = operand ? mem_q[rd_q[AW-1:0]][1:0] : 2'b00;
`ifdef ONLINE_DIGIT_CHECK_EN
        px    = (in_x == 2'b10) ? 2'b00 : in_x;
        py    = (in_y == 2'b10) ? 2'b00 : in_y;
        err_d = ((state_q == IDLE && start) ? 1'b0 : err_q)
              | (push && (in_x == 2'b10 || in_y == 2'b10));
`else
        px    = in_x;
        py    = in_y;
        err_d = 1'b0;
`endif
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = {px, py};
        wr_d     = wr_q + {{AW{1'b0}}, push};
        rd_d     = rd_q + {{AW{1'b0}}, pop};
        state_d  = state_q;
        cnt_d    = cnt_q;
        issued_d = issued_q + {9'd0, digit_valid && enable_for_input};
        case (state_q)
            IDLE: begin
                cnt_d = 9'd0;
                if (start) begin
                    state_d  = RUN;
                    issued_d = 10'd0;
                end
            end
            RUN: begin
                // an underflow freezes the count in the very cycle it is detected
                if (stall) state_d = STALL;
                else if (cnt_q == LAST) state_d = DONE;
                else cnt_d = cnt_q + 9'd1;
            end
            STALL: state_d = empty ? STALL : RUN;
            DONE: begin
                state_d = IDLE;
                cnt_d   = 9'd0;
            end
        endcase
        done_d = state_d == DONE;
        we_d   = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            issued_q <= '0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            we_q     <= we_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            mem_q    <= mem_d;
        end
    end

    assign in_ready     = !full;
    assign write_enable = we_q && !stall;
    assign cnt_master   = cnt_q;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign digit_err    = err_q;
endmodule

// File: tb/tb_online_digit_sequencer.sv
// tb_online_digit_sequencer: randomized scoreboard bench against a cycle-level behavioural model.
module tb_online_digit_sequencer;
    localparam int ND = 4, OD = 3, DEPTH = 4;
    localparam int LAST = 4 * (ND + OD) - 1;
    localparam int P_IDLE = 0, P_RUN = 1, P_STALL = 2, P_DONE = 3;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, enable_for_input = 1'b0;
    logic [1:0] in_x = 2'b00, in_y = 2'b00;
    logic       in_ready, digit_valid, write_enable, busy, done, digit_err;
    logic [1:0] x_digit, y_digit;
    logic [8:0] cnt_master;

    int checks = 0, errors = 0;
    logic [3:0] mq[$];
    int m_ph = P_IDLE, m_cnt = 0, m_iss = 0;
    bit m_err = 1'b0;

    online_digit_sequencer #(.NDIGITS(ND), .ONLINE_DELAY(OD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_ready(in_ready), .enable_for_input(enable_for_input), .x_digit(x_digit), .y_digit(y_digit),
        .digit_valid(digit_valid), .cnt_master(cnt_master), .write_enable(write_enable),
        .busy(busy), .done(done), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: phase, count and issued digits advance by the behavioural rules; mq is the scoreboard.
    always @(negedge clk) begin
        bit operand, dv, stl, pop_m, push_m;
        int sz, nph;
        logic [3:0] e;
        if (!rst_n) begin
            mq.delete();
            m_ph = P_IDLE; m_cnt = 0; m_iss = 0; m_err = 1'b0;
        end
        sz      = mq.size();
        operand = m_iss < ND;
        dv      = (m_ph == P_RUN) && (!operand || sz > 0);
        stl     = (m_ph == P_RUN) && enable_for_input && operand && sz == 0;
        chk("busy", busy, m_ph != P_IDLE);
        chk("done", done, m_ph == P_DONE);
        chk("cnt_master", cnt_master, m_cnt);
        chk("write_enable", write_enable, (m_ph == P_RUN) && !stl);
        chk("digit_valid", digit_valid, dv);
        chk("in_ready", in_ready, sz < DEPTH);
        chk("digit_err", digit_err, m_err);
        if (rst_n && digit_valid && enable_for_input) begin
            if (operand && sz == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow: got a pair with none pending at %0t", $time);
            end else begin
                e = operand ? mq[0] : 4'd0;
                chk("x_digit", x_digit, e[3:2]);
                chk("y_digit", y_digit, e[1:0]);
            end
        end
        if (rst_n) begin
            pop_m  = dv && enable_for_input && operand;
            push_m = in_valid && sz < DEPTH;
            nph    = m_ph;
            if (m_ph == P_IDLE && start) m_err = 1'b0;
            case (m_ph)
                P_IDLE: if (start) begin nph = P_RUN; m_iss = 0; end
                P_RUN: begin
                    if (stl) nph = P_STALL;
                    else if (m_cnt == LAST) nph = P_DONE;
                    else m_cnt++;
                    if (dv && enable_for_input) m_iss++;
                end
                P_STALL: if (sz > 0) nph = P_RUN;
                default: begin nph = P_IDLE; m_cnt = 0; end
            endcase
            m_ph = nph;
            if (pop_m) void'(mq.pop_front());
            if (push_m) begin
                e = {in_x, in_y};
`ifdef ONLINE_DIGIT_CHECK_EN
                if (e[3:2] == 2'b10 || e[1:0] == 2'b10) m_err = 1'b1;
                if (e[3:2] == 2'b10) e[3:2] = 2'b00;
                if (e[1:0] == 2'b10) e[1:0] = 2'b00;
`endif
                mq.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; in_valid = 1'b0; enable_for_input = 1'b0;
    endtask

    task automatic push_pair(input logic [1:0] x, input logic [1:0] y);
        in_valid = 1'b1; in_x = x; in_y = y;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (m_ph != P_IDLE && n < budget) begin
            in_valid = 1'($urandom % 2);
            in_x = 2'($urandom); in_y = 2'($urandom);
            enable_for_input = ($urandom % 3) == 0;
            step();
            n++;
        end
        quiet();
        checks++;
        if (m_ph != P_IDLE) begin
            errors++;
            $display("FAIL %s_timeout: run still active after %0d cycles", nm, budget);
        end
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        do_reset();
        // prefill four pairs, then pull every 4th cycle through the whole run
        push_pair(2'b01, 2'b01); push_pair(2'b11, 2'b01);
        push_pair(2'b00, 2'b11); push_pair(2'b01, 2'b00);
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (m_ph != P_IDLE && n < 200) begin
            enable_for_input = (n % 4) == 3;
            step();
            n++;
        end
        quiet();
        chk("prefill_run_ended", m_ph, P_IDLE);
        chk("prefill_cycles", n, LAST + 2);
        step();

        // underflow: empty FIFO with a standing request
        start = 1'b1; enable_for_input = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        chk("stall_cnt_held", cnt_master, 0);
        push_pair(2'b11, 2'b11);
        repeat (2) step();
        wait_idle("underflow", 1000);

        // backpressure: fill in IDLE, fifth push refused
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_x = 2'(i); in_y = 2'(3 - i);
            if (i == DEPTH) chk("full_in_ready", in_ready, 0);
            step();
        end
        quiet();
        start = 1'b1; step(); start = 1'b0;
        enable_for_input = 1'b1; step(); enable_for_input = 1'b0;
        chk("in_ready_after_pop", in_ready, 1);
        wait_idle("backpressure", 1000);

        // simultaneous push and pop at occupancy two
        do_reset();
        push_pair(2'b01, 2'b11); push_pair(2'b11, 2'b00);
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; in_x = 2'b00; in_y = 2'b01; enable_for_input = 1'b1;
        step();
        quiet();
        chk("occupancy_kept", mq.size(), 2);
        wait_idle("pushpop", 1000);

        // illegal digit pushed in IDLE, then a run, then a start that clears the flag
        push_pair(2'b10, 2'b01);
        push_pair(2'b01, 2'b10);
        start = 1'b1; step(); start = 1'b0;
        wait_idle("illegal", 1000);
        start = 1'b1; step(); start = 1'b0;
        wait_idle("illegal_clear", 1000);

        // async reset in the middle of a run
        for (int i = 0; i < DEPTH; i++) push_pair(2'($urandom), 2'($urandom));
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!(m_ph == P_RUN && m_cnt == 13) && n < 500) begin
            in_valid = 1'($urandom % 2); in_x = 2'($urandom); in_y = 2'($urandom);
            enable_for_input = ($urandom % 3) == 0;
            step();
            n++;
        end
        quiet();
        chk("reached_cnt13", m_cnt, 13);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_cnt", cnt_master, 0);
        chk("async_we", write_enable, 0);
        chk("async_done", done, 0);
        chk("async_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 6)) begin
                in_valid = 1'($urandom % 2); in_x = 2'($urandom); in_y = 2'($urandom);
                step();
            end
            quiet();
            start = 1'b1; step(); start = 1'b0;
            wait_idle("random", 1000);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
